// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - RV32I MEM stage: ready/valid data-memory access, load align/extend, MEM/WB register
// Optional forced-completion timeout: define MEM_STAGE_TIMEOUT_EN.
module memory_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ID_EX_bhu_reg,
    input  logic        ID_EX_b_reg,
    input  logic        ID_EX_h_reg,
    input  logic        ID_EX_w_reg,
    input  logic        ID_EX_wb_src_reg,
    input  logic        ID_EX_reg_write_reg,
    input  logic        ID_EX_mem_read_i_reg,
    input  logic        ID_EX_mem_write_i_reg,
    input  logic [31:0] EX_PC_reg,
    input  logic [31:0] ID_EX_ALU_Src2_L1_reg,
    input  logic [31:0] alu_out_reg,
    input  logic [4:0]  ID_EX_rd_reg,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic [4:0]  EX_MEM_rd_hu,
    output logic        EX_MEM_reg_write_hu,
    output logic [31:0] EX_MEM_fwd_data,
    output logic [31:0] MEM_PC_reg,
    output logic [31:0] MEM_wb_data_reg,
    output logic [4:0]  MEM_rd_reg,
    output logic        MEM_reg_write_reg,
    output logic        mem_err
);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t      state;
    logic        access;
    logic        timeout_hit;
    logic        forced;
    logic        complete;
    logic [1:0]  off;
    logic [3:0]  store_be;
    logic [31:0] store_wdata;
    logic [31:0] load_data;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] wb_data;

    assign access = ID_EX_mem_read_i_reg | ID_EX_mem_write_i_reg;
    assign off    = alu_out_reg[1:0];

`ifdef MEM_STAGE_TIMEOUT_EN
    logic [31:0] wait_cnt;
    logic        err_q;

    // The cycle that would make the count equal TIMEOUT is the forced completion.
    assign timeout_hit = (state == WAIT) && (wait_cnt == TIMEOUT - 32'd1);
    assign mem_err     = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            if (state == WAIT && !complete)
                wait_cnt <= wait_cnt + 32'd1;
            else
                wait_cnt <= 32'd0;
            if (forced)
                err_q <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign mem_err        = 1'b0;
    assign unused_timeout = |TIMEOUT;
`endif

    assign forced    = timeout_hit & ~dmem_ready;
    assign complete  = access & (dmem_ready | timeout_hit);
    assign mem_stall = access & ~complete;

    assign dmem_req   = (state == WAIT) | access;
    assign dmem_we    = ID_EX_mem_write_i_reg;
    assign dmem_addr  = {alu_out_reg[31:2], 2'b00};
    assign dmem_wdata = store_wdata;
    assign dmem_be    = ID_EX_mem_write_i_reg ? store_be : 4'hF;

    assign EX_MEM_rd_hu        = ID_EX_rd_reg;
    assign EX_MEM_reg_write_hu = ID_EX_reg_write_reg;
    assign EX_MEM_fwd_data     = alu_out_reg;

    assign byte_sel = dmem_rdata[8*off +: 8];
    assign half_sel = dmem_rdata[16*alu_out_reg[1] +: 16];

    always_comb begin
        store_be    = 4'hF;
        store_wdata = ID_EX_ALU_Src2_L1_reg;
        load_data   = dmem_rdata;
        case ({ID_EX_b_reg, ID_EX_h_reg, ID_EX_w_reg})
            3'b100: begin
                store_be    = 4'b0001 << off;
                store_wdata = {4{ID_EX_ALU_Src2_L1_reg[7:0]}};
                load_data   = ID_EX_bhu_reg ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            3'b010: begin
                store_be    = alu_out_reg[1] ? 4'b1100 : 4'b0011;
                store_wdata = {2{ID_EX_ALU_Src2_L1_reg[15:0]}};
                load_data   = ID_EX_bhu_reg ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            default: begin
                store_be    = 4'hF;
                store_wdata = ID_EX_ALU_Src2_L1_reg;
                load_data   = dmem_rdata;
            end
        endcase
        if (forced)
            load_data = 32'd0;
    end

    assign wb_data = ID_EX_wb_src_reg ? load_data : alu_out_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            MEM_PC_reg        <= 32'd0;
            MEM_wb_data_reg   <= 32'd0;
            MEM_rd_reg        <= 5'd0;
            MEM_reg_write_reg <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (access && !dmem_ready) state <= WAIT;
                WAIT:    if (dmem_ready || timeout_hit) state <= IDLE;
                default: state <= IDLE;
            endcase
            // A stalled access leaves a bubble so write-back never sees a half-done load.
            if (mem_stall) begin
                MEM_PC_reg        <= 32'd0;
                MEM_wb_data_reg   <= 32'd0;
                MEM_rd_reg        <= 5'd0;
                MEM_reg_write_reg <= 1'b0;
            end else begin
                MEM_PC_reg        <= EX_PC_reg;
                MEM_wb_data_reg   <= wb_data;
                MEM_rd_reg        <= ID_EX_rd_reg;
                MEM_reg_write_reg <= ID_EX_reg_write_reg;
            end
        end
    end

endmodule

// File: doc/memory_stage.md
# memory_stage

Fourth pipeline stage of the RV32I no-trap core. Consumes the EX/MEM pipeline register produced by the execute stage and performs the load/store on a ready/valid data-memory port. It stalls the front of the pipeline while memory is busy, aligns and extends load data, and produces the MEM/WB pipeline register for the write-back stage.

## Interface
Parameters:
- TIMEOUT, 255: maximum wait cycles on dmem_ready before a forced completion (used only with the timeout feature).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- ID_EX_bhu_reg  in  1  load is unsigned (LBU/LHU)
- ID_EX_b_reg / ID_EX_h_reg / ID_EX_w_reg  in  1 each  access size byte/half/word (one-hot)
- ID_EX_wb_src_reg  in  1  1 = write back memory data, 0 = write back ALU result
- ID_EX_reg_write_reg  in  1  instruction writes rd
- ID_EX_mem_read_i_reg  in  1  load
- ID_EX_mem_write_i_reg  in  1  store
- EX_PC_reg  in  32  instruction PC
- ID_EX_ALU_Src2_L1_reg  in  32  store data (rs2)
- alu_out_reg  in  32  effective address / ALU result
- ID_EX_rd_reg  in  5  destination register
- dmem_req  out  1  memory request valid
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word address {alu_out_reg[31:2],2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ready  in  1  memory completes the current request this cycle
- dmem_rdata  in  32  read word, valid when dmem_ready
- mem_stall  out  1  freeze PC/IF/ID/EX and EX_MEM_en low
- EX_MEM_rd_hu  out  5  rd for the hazard/forwarding unit
- EX_MEM_reg_write_hu  out  1  reg_write for forwarding
- EX_MEM_fwd_data  out  32  alu_out_reg, for forwarding
- MEM_PC_reg  out  32  PC in MEM/WB
- MEM_wb_data_reg  out  32  selected write-back value
- MEM_rd_reg  out  5  rd in MEM/WB
- MEM_reg_write_reg  out  1  write enable in MEM/WB
- mem_err  out  1  sticky timeout flag (0 when the feature is compiled out)

## Operation
- access = mem_read_i | mem_write_i. Non-access instructions pass straight to MEM/WB with wb_data = alu_out_reg, 0 wait cycles.
- FSM states IDLE, WAIT.
  - IDLE: dmem_req = access. If access and dmem_ready: complete, stay in IDLE. If access and not dmem_ready: go to WAIT.
  - WAIT: dmem_req = 1, outputs held stable because EX/MEM is frozen. dmem_ready: complete, go to IDLE.
- mem_stall = access & ~complete, combinational.
- MEM/WB loads every cycle. When mem_stall = 1 it loads a bubble (reg_write = 0, rd = 0, data = 0). Otherwise it loads the live instruction.
- Store, off = addr[1:0]:
  - b: be = 4'b0001<<off, wdata = {4{rs2[7:0]}}.
  - h: be = 4'b0011<<(2*addr[1]), wdata = {2{rs2[15:0]}}.
  - w: be = 4'hF, wdata = rs2.
- Load:
  - b: byte at rdata[8*off+:8], sign-extended unless bhu.
  - h: rdata[16*addr[1]+:16], sign-extended unless bhu; addr[0] ignored.
  - w: rdata; addr[1:0] ignored.
- Misalignment never traps. It is resolved within the aligned word as above.
- For loads dmem_be = 4'hF and dmem_we = 0.
- If mem_read and mem_write are both set, the store takes priority.
- wb_data = wb_src ? load_data : alu_out_reg.

## Timing
- Reset (rst high at a clk edge) gives:
  - state IDLE, timeout counter 0, mem_err 0
  - all MEM_* outputs 0
- A reset asserted while in WAIT abandons the request. dmem_req drops in the cycle after reset.
- Zero-wait memory: the load result appears in MEM/WB one clk after the instruction is in EX/MEM, with no stall.
- N wait cycles: mem_stall is high for exactly N cycles, and MEM/WB receives N bubbles and then the result.
- dmem_rdata is sampled only in the cycle dmem_ready is high. dmem_ready while dmem_req is low is ignored.
- Back-to-back accesses: a new request may issue in the cycle after completion. There is no idle cycle.

## Configuration
- MEM_STAGE_TIMEOUT_EN defined:
  - A counter increments each WAIT cycle.
  - When the count reaches TIMEOUT, the access completes forcibly. Load data is 0, the store is dropped, mem_err is set and stays set until rst. The FSM returns to IDLE.
  - The counter clears on completion.
- MEM_STAGE_TIMEOUT_EN undefined: no counter. WAIT lasts until dmem_ready. mem_err is tied to 0.

## Test plan
- Zero-wait LW: addr 0x100, rdata 0xDEADBEEF, ready in the same cycle. Required: mem_stall stays 0, and next cycle MEM_wb_data_reg = 0xDEADBEEF with MEM_reg_write_reg = 1.
- LB / LBU: addr 0x103, rdata 0x80FF_0000. Required: LB yields 0xFFFFFF80, LBU yields 0x00000080.
- SH: addr 0x202, rs2 0x1234ABCD. Required: dmem_be = 4'b1100, dmem_wdata = 0xABCDABCD, dmem_addr = 0x200, dmem_we = 1.
- 3-wait LW: ready arrives on the 4th request cycle. Required: mem_stall high 3 cycles, MEM/WB holds 3 bubbles (reg_write 0), then the data.
- Reset mid-WAIT: rst is asserted during wait cycle 2. Required: next cycle state is IDLE, all MEM_* outputs are 0, dmem_req is 0.
- With MEM_STAGE_TIMEOUT_EN and TIMEOUT = 4: dmem_ready is never asserted. Required: completion after 4 WAIT cycles, wb_data 0, mem_err 1 and sticky until rst.
